m_alarm_ctrl: RTL and testbench
===============================

Name: m_alarm_ctrl

Overview:
- Downstream consumer of the clock's hour, minute and second digit outputs.
- Holds an editable alarm time, adjusted by the same manual up/down pulses the set-mode logic generates.
- Compares the alarm time with the running time and drives the alarm state machine: idle, ringing, snooze.
- Produces a buzzer drive, status LEDs and BCD alarm digits for the display mux.

Parameters:
- DEF_HR, 6, alarm hour after reset (0-23)
- DEF_MIN, 0, alarm minute after reset (0-59)
- RING_SEC, 60, seconds of ringing before auto-stop
- SNOOZE_SEC, 300, seconds in snooze before re-ringing

Ports:
- clk  in  1  system clock; all state updates on posedge clk
- rst  in  1  synchronous, active-high reset
- tick_sec  in  1  one-clk pulse once per second, aligned with the seconds counter increment
- hr1  in  4  current hour tens, BCD
- hr0  in  4  current hour units, BCD
- min1  in  3  current minute tens, 0-5
- min0  in  4  current minute units, BCD
- sec1  in  3  current second tens
- sec0  in  4  current second units
- al_set  in  1  alarm-edit mode; high enables editing
- up_min  in  1  one-clk increment pulse, alarm minute
- down_min  in  1  one-clk decrement pulse, alarm minute
- up_hr  in  1  one-clk increment pulse, alarm hour
- down_hr  in  1  one-clk decrement pulse, alarm hour
- al_en  in  1  alarm armed (switch level)
- snooze  in  1  one-clk pulse from the snooze button
- stop  in  1  one-clk pulse from the stop button
- al_hr1  out  4  alarm hour tens, BCD, registered
- al_hr0  out  4  alarm hour units, BCD, registered
- al_min1  out  3  alarm minute tens, registered
- al_min0  out  4  alarm minute units, registered
- ringing  out  1  high in the RING state
- snoozing  out  1  high in the SNOOZE state
- buzzer  out  1  gated beep enable

Behaviour:
- Reset:
  - al_hr = DEF_HR, al_min = DEF_MIN; BCD outputs reflect these one cycle after rst deasserts.
  - State IDLE. ringing, snoozing and buzzer are 0. All counters are 0. The match register is 0.
- Alarm edit:
  - Only while al_set = 1.
  - al_min is binary 0-59. Increment wraps 59 -> 0; decrement wraps 0 -> 59.
  - al_hr is binary 0-23. Increment wraps 23 -> 0; decrement wraps 0 -> 23.
  - Up and down asserted in the same cycle on the same field: no change.
  - Minute wrap never carries into the hour.
  - Pulses are ignored when al_set = 0.
  - Editing is legal in any FSM state and does not change the state.
- BCD outputs: registered, one-cycle latency from the binary registers.
- Match:
  - match = (hr1, hr0, min1, min0) equal to the registered alarm BCD, and sec1 = 0 and sec0 = 0.
  - match_q is match delayed one cycle.
  - trigger = match & ~match_q & al_en. It fires once per alarm minute and never re-fires within the same second.
- FSM transitions:
  - IDLE -> RING on trigger. Ring counter is cleared.
  - RING:
    - On each tick_sec, the ring counter increments.
    - When the ring counter reaches RING_SEC on a tick, go to IDLE.
    - snooze pulse -> SNOOZE, with the snooze counter cleared.
    - stop pulse -> IDLE.
  - SNOOZE:
    - On each tick_sec, the snooze counter increments.
    - At SNOOZE_SEC, go to RING with the ring counter cleared.
    - stop pulse -> IDLE.
    - snooze pulse is ignored.
- FSM priority, per cycle: rst > ~al_en (forces IDLE from any state) > stop > snooze > timeout > trigger.
- trigger is ignored in RING and SNOOZE.
- Counter widths are sized from RING_SEC and SNOOZE_SEC. Counters saturate and cannot overflow.
- Beep gating:
  - A phase bit toggles on every tick_sec while in RING and is cleared on RING entry.
  - buzzer = ringing & ~phase: 1 s on, 1 s off, starting on immediately.
- Output timing: ringing and snoozing are registered state decodes. They change the cycle after the causing input.
- tick_sec and trigger in the same cycle while in IDLE: enter RING; the tick is not counted.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE = 2'd0, S_RING = 2'd1, S_SNOOZE = 2'd2
  - hour and minute limits 23 and 59
- One sub-module: m_bin2bcd_2d, a registered binary(0-59) to two-digit BCD converter.
  - Instantiated twice: hour and minute.
  - The same converter serves the display path.

Test Plan:
1. Reset; hold al_set = 0 -> al_hr1:al_hr0:al_min1:al_min0 = 0:6:0:0; ringing = 0; buzzer = 0.
2. al_set = 1; apply 3 down_min pulses -> minute shows 5:7. Then apply up_hr 18 times -> hour shows 0:0 (6 + 18 wraps 24 -> 0). Then apply up_min and down_min in the same cycle -> no change.
3. Alarm 06:00, al_en = 1; drive time 05:59:59, then 06:00:00 -> ringing = 1 the next cycle and buzzer = 1. After the next tick_sec, buzzer = 0. Holding 06:00:00 for many cycles gives no retrigger.
4. Ringing; snooze pulse -> snoozing = 1, buzzer = 0. After 300 tick_sec pulses -> ringing = 1 again. Then stop pulse -> IDLE.
5. Ringing with no input -> after 60 tick_sec pulses, ringing = 0 automatically. Repeat with al_en dropped mid-ring -> IDLE the next cycle.
6. al_en = 0 at match -> no ringing. Raise al_en during 06:00:00 -> no trigger, because match_q is already 1. Assert rst during SNOOZE -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/m_alarm_ctrl_pkg.sv
// Alarm controller shared types: FSM state encoding, time field limits
// and the wrap-around step helper used by the alarm edit logic.
package m_alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  localparam logic [5:0] HR_MAX  = 6'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // up and down together cancel out
  function automatic logic [5:0] step_wrap(
    input logic [5:0] v,
    input logic       up,
    input logic       dn,
    input logic [5:0] max
  );
    logic [5:0] r;
    r = v;
    if (up && !dn)
      r = (v >= max) ? 6'd0 : v + 6'd1;
    else if (dn && !up)
      r = (v == 6'd0) ? max : v - 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/m_alarm_ctrl_if.sv
// Time bus between the clock core and the alarm controller.
// master: clock side drives time digits; slave: alarm drives alarm digits.
interface m_alarm_ctrl_if;

  logic       tick_sec;
  logic [3:0] hr1;
  logic [3:0] hr0;
  logic [2:0] min1;
  logic [3:0] min0;
  logic [2:0] sec1;
  logic [3:0] sec0;

  logic [3:0] al_hr1;
  logic [3:0] al_hr0;
  logic [2:0] al_min1;
  logic [3:0] al_min0;

  modport master (
    output tick_sec, hr1, hr0,
    output min1, min0, sec1, sec0,
    input  al_hr1, al_hr0,
    input  al_min1, al_min0
  );

  modport slave (
    input  tick_sec, hr1, hr0,
    input  min1, min0, sec1, sec0,
    output al_hr1, al_hr0,
    output al_min1, al_min0
  );

endinterface

// File: rtl/m_bin2bcd_2d.sv
// Registered binary (0-59) to two BCD digits; d1 tens (TW bits), d0 units.
// Ports: clk, rst (sync, active high), bin in, d1/d0 registered out.
module m_bin2bcd_2d #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    bin,
  output logic [TW-1:0] d1,
  output logic [3:0]    d0
);

  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens = 4'd0;
    ones = 4'(bin);
    if (bin >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(bin - 6'd10);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      d0 <= '0;
    end else begin
      d1 <= TW'(tens);
      d0 <= ones;
    end
  end

endmodule

// File: rtl/m_alarm_ctrl.sv
// Alarm controller: editable alarm time, match/trigger, ring/snooze FSM.
// Ports: clk, rst, bus (time in / alarm BCD out), edit pulses, al_en, snooze, stop, status.
import m_alarm_ctrl_pkg::*;

module m_alarm_ctrl #(
  parameter int DEF_HR     = 6,
  parameter int DEF_MIN    = 0,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic          clk,
  input  logic          rst,
  m_alarm_ctrl_if.slave bus,
  input  logic          al_set,
  input  logic          up_min,
  input  logic          down_min,
  input  logic          up_hr,
  input  logic          down_hr,
  input  logic          al_en,
  input  logic          snooze,
  input  logic          stop,
  output logic          ringing,
  output logic          snoozing,
  output logic          buzzer
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam logic [RW-1:0] RING_LIM = RW'(RING_SEC);
  localparam logic [SW-1:0] SNZ_LIM  = SW'(SNOOZE_SEC);

  logic [5:0] al_hr_q;
  logic [5:0] al_min_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      al_hr_q  <= 6'(DEF_HR);
      al_min_q <= 6'(DEF_MIN);
    end else if (al_set) begin
      al_hr_q  <= step_wrap(al_hr_q, up_hr, down_hr, HR_MAX);
      al_min_q <= step_wrap(al_min_q, up_min, down_min, MIN_MAX);
    end
  end

  m_bin2bcd_2d #(.TW(4)) u_hr_bcd (
    .clk (clk),
    .rst (rst),
    .bin (al_hr_q),
    .d1  (bus.al_hr1),
    .d0  (bus.al_hr0)
  );

  m_bin2bcd_2d #(.TW(3)) u_min_bcd (
    .clk (clk),
    .rst (rst),
    .bin (al_min_q),
    .d1  (bus.al_min1),
    .d0  (bus.al_min0)
  );

  logic match;
  logic match_q;
  logic trigger;

  assign match = (bus.hr1 == bus.al_hr1) &&
                 (bus.hr0 == bus.al_hr0) &&
                 (bus.min1 == bus.al_min1) &&
                 (bus.min0 == bus.al_min0) &&
                 (bus.sec1 == 3'd0) &&
                 (bus.sec0 == 4'd0);

  // rising edge only, so a held 00 second never re-fires
  assign trigger = match & ~match_q & al_en;

  state_t        state_q, state_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [SW-1:0] snz_q, snz_d;
  logic          phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ring_q  <= '0;
      snz_q   <= '0;
      phase_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      phase_q <= phase_d;
      match_q <= match;
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    phase_d = phase_q;
    if (!al_en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_d = S_RING;
            ring_d  = '0;
            phase_d = 1'b0;
          end
        end
        S_RING: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (snooze) begin
            state_d = S_SNOOZE;
            snz_d   = '0;
          end else if (bus.tick_sec) begin
            phase_d = ~phase_q;
            if (ring_q < RING_LIM)
              ring_d = ring_q + 1'b1;
            if (ring_q + 1'b1 >= RING_LIM)
              state_d = S_IDLE;
          end
        end
        S_SNOOZE: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (bus.tick_sec) begin
            if (snz_q < SNZ_LIM)
              snz_d = snz_q + 1'b1;
            if (snz_q + 1'b1 >= SNZ_LIM) begin
              state_d = S_RING;
              ring_d  = '0;
              phase_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign ringing  = (state_q == S_RING);
  assign snoozing = (state_q == S_SNOOZE);
  assign buzzer   = ringing & ~phase_q;

endmodule

// File: tb/tb_m_alarm_ctrl.sv
// Scoreboard bench for m_alarm_ctrl: directed stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_m_alarm_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic al_set, up_min, down_min, up_hr, down_hr;
  logic al_en, snooze, stop;
  logic ringing, snoozing, buzzer;

  always #5 clk = ~clk;

  m_alarm_ctrl_if bus ();

  m_alarm_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .al_set   (al_set),
    .up_min   (up_min),
    .down_min (down_min),
    .up_hr    (up_hr),
    .down_hr  (down_hr),
    .al_en    (al_en),
    .snooze   (snooze),
    .stop     (stop),
    .ringing  (ringing),
    .snoozing (snoozing),
    .buzzer   (buzzer)
  );

  typedef struct {
    string       name;
    logic [17:0] v;
    logic [17:0] m;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [17:0] ALL  = 18'h3ffff;
  localparam logic [17:0] STAT = 18'h00007;

  logic [17:0] obs;
  assign obs = {bus.al_hr1, bus.al_hr0, bus.al_min1,
                bus.al_min0, ringing, snoozing, buzzer};

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s: got %h expected %h (mask %h)",
                 e.name, obs, e.v, e.m);
      end
    end
  end

  function automatic logic [17:0] ov(
    input logic [3:0] h1, input logic [3:0] h0,
    input logic [2:0] m1, input logic [3:0] m0,
    input logic r, input logic s, input logic b
  );
    return {h1, h0, m1, m0, r, s, b};
  endfunction

  task automatic expect_o(input string n,
                          input logic [17:0] v,
                          input logic [17:0] m);
    exp_t e;
    e.name = n;
    e.v = v;
    e.m = m;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input logic [3:0] h1, input logic [3:0] h0,
                          input logic [2:0] m1, input logic [3:0] m0,
                          input logic [2:0] s1, input logic [3:0] s0);
    bus.hr1 = h1;
    bus.hr0 = h0;
    bus.min1 = m1;
    bus.min0 = m0;
    bus.sec1 = s1;
    bus.sec0 = s0;
  endtask

  task automatic ticks(input int n);
    bus.tick_sec = 1'b1;
    cyc(n);
    bus.tick_sec = 1'b0;
  endtask

  // 05:59:59 then 06:00:00, leaves the time at 06:00:00
  task automatic hit_alarm();
    set_time(4'd0, 4'd5, 3'd5, 4'd9, 3'd5, 4'd9);
    cyc(2);
    set_time(4'd0, 4'd6, 3'd0, 4'd0, 3'd0, 4'd0);
    cyc(1);
  endtask

  initial begin
    rst = 1'b1;
    al_set = 0; up_min = 0; down_min = 0;
    up_hr = 0; down_hr = 0;
    al_en = 0; snooze = 0; stop = 0;
    bus.tick_sec = 1'b0;
    set_time(4'd1, 4'd2, 3'd0, 4'd0, 3'd0, 4'd0);
    cyc(3);
    rst = 1'b0;
    cyc(1);
    expect_o("reset", ov(0, 6, 0, 0, 0, 0, 0), ALL);

    // edit is ignored without al_set
    up_min = 1; cyc(1); up_min = 0; cyc(1);
    expect_o("edit_ignored", ov(0, 6, 0, 0, 0, 0, 0), ALL);

    al_set = 1;
    repeat (3) begin
      down_min = 1; cyc(1); down_min = 0; cyc(1);
    end
    expect_o("min_wrap_down", ov(0, 6, 5, 7, 0, 0, 0), ALL);
    repeat (18) begin
      up_hr = 1; cyc(1); up_hr = 0; cyc(1);
    end
    expect_o("hr_wrap_up", ov(0, 0, 5, 7, 0, 0, 0), ALL);
    up_min = 1; down_min = 1; cyc(1);
    up_min = 0; down_min = 0; cyc(1);
    expect_o("up_dn_cancel", ov(0, 0, 5, 7, 0, 0, 0), ALL);
    repeat (3) begin
      up_min = 1; cyc(1); up_min = 0; cyc(1);
    end
    expect_o("min_wrap_no_carry", ov(0, 0, 0, 0, 0, 0, 0), ALL);
    down_hr = 1; cyc(1); down_hr = 0; cyc(1);
    expect_o("hr_wrap_down", ov(2, 3, 0, 0, 0, 0, 0), ALL);
    repeat (7) begin
      up_hr = 1; cyc(1); up_hr = 0; cyc(1);
    end
    expect_o("hr_restore", ov(0, 6, 0, 0, 0, 0, 0), ALL);
    al_set = 0;

    // ring and beep
    al_en = 1;
    set_time(4'd0, 4'd5, 3'd5, 4'd9, 3'd5, 4'd9);
    cyc(2);
    expect_o("pre_match", ov(0, 6, 0, 0, 0, 0, 0), ALL);
    set_time(4'd0, 4'd6, 3'd0, 4'd0, 3'd0, 4'd0);
    cyc(1);
    expect_o("ring_on", ov(0, 6, 0, 0, 1, 0, 1), ALL);
    ticks(1);
    expect_o("beep_off", ov(0, 6, 0, 0, 1, 0, 0), ALL);
    cyc(20);
    expect_o("ring_hold", ov(0, 6, 0, 0, 1, 0, 0), ALL);

    // snooze then re-ring
    snooze = 1; cyc(1); snooze = 0;
    expect_o("snooze_in", ov(0, 6, 0, 0, 0, 1, 0), ALL);
    snooze = 1; cyc(1); snooze = 0;
    expect_o("snooze_ignored", ov(0, 6, 0, 0, 0, 1, 0), ALL);
    ticks(299);
    expect_o("snooze_299", ov(0, 6, 0, 0, 0, 1, 0), ALL);
    ticks(1);
    expect_o("re_ring", ov(0, 6, 0, 0, 1, 0, 1), ALL);
    stop = 1; cyc(1); stop = 0;
    expect_o("stop", ov(0, 6, 0, 0, 0, 0, 0), ALL);

    // auto-stop; tick on the trigger edge is not counted
    set_time(4'd0, 4'd5, 3'd5, 4'd9, 3'd5, 4'd9);
    cyc(2);
    set_time(4'd0, 4'd6, 3'd0, 4'd0, 3'd0, 4'd0);
    bus.tick_sec = 1'b1;
    cyc(1);
    bus.tick_sec = 1'b0;
    expect_o("ring_tick_same", ov(0, 6, 0, 0, 1, 0, 1), ALL);
    ticks(59);
    expect_o("ring_59", ov(0, 6, 0, 0, 1, 0, 0), ALL);
    ticks(1);
    expect_o("auto_stop", ov(0, 6, 0, 0, 0, 0, 0), ALL);
    cyc(5);
    expect_o("no_retrigger", ov(0, 6, 0, 0, 0, 0, 0), ALL);

    // al_en drop mid-ring
    hit_alarm();
    ticks(10);
    expect_o("ring_10", ov(0, 6, 0, 0, 1, 0, 1), ALL);
    al_en = 0; cyc(1);
    expect_o("en_drop", ov(0, 6, 0, 0, 0, 0, 0), ALL);

    // disarmed at match, then armed late
    hit_alarm();
    expect_o("disarmed", ov(0, 6, 0, 0, 0, 0, 0), ALL);
    al_en = 1; cyc(3);
    expect_o("late_arm", ov(0, 6, 0, 0, 0, 0, 0), ALL);

    // reset during snooze; edit in snooze keeps state
    hit_alarm();
    expect_o("ring_again", ov(0, 6, 0, 0, 1, 0, 1), ALL);
    snooze = 1; cyc(1); snooze = 0;
    al_set = 1; up_min = 1; cyc(1); up_min = 0; cyc(1);
    al_set = 0;
    expect_o("edit_in_snooze", ov(0, 6, 0, 1, 0, 1, 0), ALL);
    rst = 1; cyc(1);
    expect_o("rst_status", ov(0, 0, 0, 0, 0, 0, 0), STAT);
    rst = 0; cyc(1);
    expect_o("rst_values", ov(0, 6, 0, 0, 0, 0, 0), ALL);

    cyc(1);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
